// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared operator codes, dtype codes and FSM encoding for the calculator ALU
package alu_pkg;

    localparam int         WIDTH_DFLT  = 16;

    localparam logic [4:0] OP_MUL      = 5'h03;
    localparam logic [4:0] OP_DIV      = 5'h04;

    localparam logic [3:0] DT_UNSIGNED = 4'h2;

    typedef enum logic [1:0] {
        IDLE = 2'h0,
        CALC = 2'h1,
        DONE = 2'h2
    } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH:0]   rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // A clear borrow bit means the divisor fits: keep the difference and emit a 1.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr};
        if (!trial[WIDTH]) begin
            rem_nxt = trial;
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted;
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/shift_sub_div.sv
// rtl/shift_sub_div.sv - unsigned restoring shift-subtract divider, one quotient bit per clock
module shift_sub_div
    import alu_pkg::state_t, alu_pkg::IDLE, alu_pkg::CALC, alu_pkg::DONE, alu_pkg::WIDTH_DFLT;
#(
    parameter int         WIDTH       = WIDTH_DFLT,
    parameter logic [4:0] OP_DIV      = alu_pkg::OP_DIV,
    parameter logic [3:0] DT_UNSIGNED = alu_pkg::DT_UNSIGNED
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [3:0]         dtype,
    input  logic [4:0]         operator,
    input  logic [WIDTH-1:0]   src1,
    input  logic [WIDTH-1:0]   src2,
    input  logic               parser_done,
    output logic [2*WIDTH-1:0] calc_res,
    output logic               alu_done,
    output logic               div_err,
    output logic               busy
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] calc_res_q, calc_res_d;
    logic               div_err_q, div_err_d;
    logic               alu_done_q, alu_done_d;
    logic               busy_q, busy_d;

    logic [WIDTH:0]     step_rem;
    logic [WIDTH-1:0]   step_quo;
    logic               start;
    logic               unused_rem_msb;

    // The remainder stays below the divisor, so its top bit never feeds the next step.
    assign unused_rem_msb = rem_q[WIDTH];

    div_step #(
        .WIDTH   (WIDTH)
    ) u_div_step (
        .rem     (rem_q[WIDTH-1:0]),
        .quo     (quo_q),
        .dvsr    (dvsr_q),
        .rem_nxt (step_rem),
        .quo_nxt (step_quo)
    );

    assign start = parser_done && (dtype == DT_UNSIGNED) && (operator == OP_DIV);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        cnt_d      = cnt_q;
        calc_res_d = calc_res_q;
        div_err_d  = div_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (src2 == '0) begin
                        // Divide-by-zero skips iteration: remainder = dividend, quotient = all ones.
                        calc_res_d = {src1, {WIDTH{1'b1}}};
                        div_err_d  = 1'b1;
                        state_d    = DONE;
                    end else begin
                        quo_d     = src1;
                        dvsr_d    = src2;
                        rem_d     = '0;
                        cnt_d     = '0;
                        div_err_d = 1'b0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    calc_res_d = {step_rem[WIDTH-1:0], step_quo};
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        alu_done_d = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            cnt_q      <= '0;
            calc_res_q <= '0;
            div_err_q  <= 1'b0;
            alu_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            cnt_q      <= cnt_d;
            calc_res_q <= calc_res_d;
            div_err_q  <= div_err_d;
            alu_done_q <= alu_done_d;
            busy_q     <= busy_d;
        end
    end

    assign calc_res = calc_res_q;
    assign div_err  = div_err_q;
    assign alu_done = alu_done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_shift_sub_div.sv
// tb/tb_shift_sub_div.sv - randomized and directed bench for shift_sub_div against a behavioural model
module tb_shift_sub_div;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic [3:0]     dtype = 4'h0;
    logic [4:0]     operator = 5'h0;
    logic [W-1:0]   src1 = '0;
    logic [W-1:0]   src2 = '0;
    logic           parser_done = 1'b0;
    logic [2*W-1:0] calc_res;
    logic           alu_done;
    logic           div_err;
    logic           busy;

    shift_sub_div dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .dtype       (dtype),
        .operator    (operator),
        .src1        (src1),
        .src2        (src2),
        .parser_done (parser_done),
        .calc_res    (calc_res),
        .alu_done    (alu_done),
        .div_err     (div_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: edge index, edge of the last accepted request and edge after which DONE is visible.
    int             e         = 0;
    int             acc_edge  = -100;
    int             done_edge = -100;
    logic [2*W-1:0] exp_res   = '0;
    logic [2*W-1:0] pend_res  = '0;
    logic           exp_err   = 1'b0;

    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {a, {W{1'b1}}};
        return {W'(a % b), W'(a / b)};
    endfunction

    always @(posedge clk) begin
        e = e + 1;
        if (!n_rst) begin
            acc_edge  = -100;
            done_edge = -100;
            exp_res   = '0;
            exp_err   = 1'b0;
        end else begin
            if (parser_done && dtype == 4'h2 && operator == 5'h04 && e >= done_edge + 2) begin
                acc_edge  = e;
                pend_res  = ref_div(src1, src2);
                exp_err   = (src2 == '0);
                done_edge = (src2 == '0) ? e : e + W;
            end
            if (e == done_edge) exp_res = pend_res;
        end
    end

    task automatic check_bit(input string name, input logic act, input logic expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=%0b expected=%0b (edge %0d)", name, act, expv, e);
        end
    endtask

    task automatic check_vec(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h (edge %0d)", name, act, expv, e);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d (edge %0d)", name, act, expv, e);
        end
    endtask

    always @(negedge clk) begin
        check_bit("alu_done", alu_done, e == done_edge);
        check_bit("busy", busy, e >= acc_edge && e <= done_edge);
        check_bit("div_err", div_err, exp_err);
        check_vec("calc_res", calc_res, exp_res);
    end

    // Returns edges from acceptance to the alu_done cycle, or -1 if none within max_wait.
    task automatic wait_done(input int k, input int max_wait, output int lat,
                             output logic [2*W-1:0] res, output logic err);
        lat = -1;
        res = 'x;
        err = 1'bx;
        for (int i = 0; i < max_wait; i++) begin
            if (alu_done) begin
                lat = e - k;
                res = calc_res;
                err = div_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op,
                          input logic [3:0] dt, input int max_wait, output int lat,
                          output logic [2*W-1:0] res, output logic err);
        int k;
        @(negedge clk);
        src1        = a;
        src2        = b;
        operator    = op;
        dtype       = dt;
        parser_done = 1'b1;
        @(negedge clk);
        k           = e;
        parser_done = 1'b0;
        wait_done(k, max_wait, lat, res, err);
    endtask

    task automatic expect_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] want, input logic want_err, input int want_lat);
        int             lat;
        logic [2*W-1:0] res;
        logic           err;
        run_op(a, b, 5'h04, 4'h2, 40, lat, res, err);
        check_int({name, " latency"}, lat, want_lat);
        check_vec({name, " result"}, res, want);
        check_bit({name, " div_err"}, err, want_err);
    endtask

    initial begin
        int             lat;
        int             k;
        logic [2*W-1:0] res;
        logic           err;
        logic [W-1:0]   a, b;
        logic [4:0]     op;
        logic [3:0]     dt;

        repeat (3) @(negedge clk);
        check_vec("reset calc_res", calc_res, '0);
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset alu_done", alu_done, 1'b0);
        check_bit("reset div_err", div_err, 1'b0);
        n_rst = 1'b1;

        expect_op("basic 100/7", 16'd100, 16'd7, 32'h0002_000E, 1'b0, 16);
        expect_op("ffff/1", 16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b0, 16);
        expect_op("ffff/ffff", 16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0, 16);
        expect_op("3/10", 16'd3, 16'd10, 32'h0003_0000, 1'b0, 16);
        expect_op("0/5", 16'd0, 16'd5, 32'h0000_0000, 1'b0, 16);
        expect_op("div0", 16'h1234, 16'h0000, 32'h1234_FFFF, 1'b1, 0);
        expect_op("9/3", 16'd9, 16'd3, 32'h0000_0003, 1'b0, 16);

        run_op(16'd5, 16'd1, 5'h03, 4'h2, 40, lat, res, err);
        check_int("reject operator", lat, -1);
        check_vec("reject operator hold", calc_res, 32'h0000_0003);
        check_bit("reject operator busy", busy, 1'b0);
        run_op(16'd5, 16'd1, 5'h04, 4'h1, 40, lat, res, err);
        check_int("reject dtype", lat, -1);
        check_vec("reject dtype hold", calc_res, 32'h0000_0003);

        // A second request mid-CALC must be dropped.
        @(negedge clk);
        src1 = 16'd200; src2 = 16'd9; operator = 5'h04; dtype = 4'h2; parser_done = 1'b1;
        @(negedge clk);
        k = e;
        parser_done = 1'b0;
        repeat (4) @(negedge clk);
        src1 = 16'd77; src2 = 16'd0; parser_done = 1'b1;
        @(negedge clk);
        parser_done = 1'b0;
        wait_done(k, 40, lat, res, err);
        check_int("pulse in calc latency", lat, 16);
        check_vec("pulse in calc result", res, 32'h0002_0016);

        // Reset during cycle k+8 of a 100/7 divide.
        @(negedge clk);
        src1 = 16'd100; src2 = 16'd7; parser_done = 1'b1;
        @(negedge clk);
        k = e;
        parser_done = 1'b0;
        repeat (7) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_vec("mid reset calc_res", calc_res, '0);
        check_bit("mid reset busy", busy, 1'b0);
        check_bit("mid reset alu_done", alu_done, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        wait_done(k, 25, lat, res, err);
        check_int("no done after reset", lat, -1);
        expect_op("50/6", 16'd50, 16'd6, 32'h0002_0008, 1'b0, 16);

        for (int i = 0; i < 200; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                default: b = W'($urandom);
            endcase
            op = ($urandom_range(0, 9) == 0) ? 5'h03 : 5'h04;
            dt = ($urandom_range(0, 9) == 0) ? 4'h1 : 4'h2;
            run_op(a, b, op, dt, (op == 5'h04 && dt == 4'h2) ? 20 : 3, lat, res, err);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_sub_div.md
Name: shift_sub_div

Overview:
- Unsigned restoring shift-subtract divider for the UART calculator ALU.
- It is the inverse counterpart of the shift-add multiplier, and uses the same parser handshake: parser_done in, alu_done out.
- Divides src1 (dividend) by src2 (divisor) over WIDTH iterations, one quotient bit per clock.
- Returns quotient and remainder packed in calc_res, and flags divide-by-zero.

Parameters:
- WIDTH, 16, operand width. calc_res is 2*WIDTH bits.
- OP_DIV, 5'h04, operator code accepted as divide.
- DT_UNSIGNED, 4'h2, dtype code accepted (unsigned).

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- dtype  in  4  operand type from parser; only DT_UNSIGNED is accepted.
- operator  in  5  operation code from parser; only OP_DIV is accepted.
- src1  in  WIDTH  dividend.
- src2  in  WIDTH  divisor.
- parser_done  in  1  operands valid; sampled in IDLE only.
- calc_res  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
- alu_done  out  1  one-cycle pulse; result valid.
- div_err  out  1  divide-by-zero flag for the current result.
- busy  out  1  high in CALC and DONE.

Behaviour:
- Reset (n_rst low, any time, including mid-operation):
  - State goes to IDLE.
  - calc_res, div_err, alu_done, busy all go to 0.
  - Internal rem, quo, dvsr and cnt all go to 0.
- States:
  - IDLE -> CALC when parser_done=1, dtype==DT_UNSIGNED, operator==OP_DIV and src2!=0.
  - IDLE -> DONE when the same conditions hold but src2==0.
  - CALC -> DONE when cnt==WIDTH-1.
  - DONE -> IDLE unconditionally.
- Accept edge, normal case (IDLE, conditions met, src2!=0):
  - Latch quo<=src1, dvsr<=src2, rem<=0, cnt<=0.
  - Clear div_err.
- Accept edge, divide-by-zero (src2==0):
  - calc_res <= {src1, {WIDTH{1'b1}}}, i.e. remainder=dividend, quotient=all ones.
  - div_err <= 1.
  - No CALC cycles.
- parser_done with a non-matching dtype or operator: ignored, stay in IDLE, outputs unchanged.
- parser_done while in CALC or DONE: ignored, with no queuing.
- CALC iteration, one per cycle:
  - trial = {rem[WIDTH-1:0], quo[WIDTH-1]} - {1'b0, dvsr}, computed at WIDTH+1 bits.
  - If trial[WIDTH]==0: rem<=trial, quo<={quo[WIDTH-2:0],1'b1}.
  - Else: rem<={rem[WIDTH-1:0], quo[WIDTH-1]}, quo<={quo[WIDTH-2:0],1'b0}.
  - cnt<=cnt+1.
- On the last CALC cycle (cnt==WIDTH-1): calc_res is loaded with the final {rem, quo} values computed that cycle.
- rem is WIDTH+1 bits internally. The final remainder is always < dvsr, so only the low WIDTH bits are reported.
- Latency:
  - parser_done is sampled at edge k.
  - Normal case: CALC is active in cycles k+1..k+WIDTH, DONE in cycle k+WIDTH+1, so alu_done is high for exactly that one cycle (k+17 for WIDTH=16).
  - Divide-by-zero: DONE in cycle k+1.
- Result hold: calc_res and div_err keep their value after DONE until the next accepted operation or reset.
- Back-to-back: a new parser_done is accepted in the first IDLE cycle after DONE. The earliest restart is one cycle after the alu_done pulse.
- alu_done is registered from state==DONE, so the pulse is glitch-free.

Decomposition:
- Shared package (alu_pkg) holds:
  - Operator codes: OP_MUL=5'h03, OP_DIV=5'h04.
  - DT_UNSIGNED=4'h2.
  - State encodings: IDLE=2'h0, CALC=2'h1, DONE=2'h2.
  - WIDTH default.
- Optional sub-module div_step: combinational single iteration (rem, quo, dvsr -> next rem, next quo). It is reusable if the divider is later unrolled to 2 bits per cycle.
- FSM, counter and registers stay in shift_sub_div.

Test Plan:
- Basic divide: src1=100, src2=7, operator=5'h04, dtype=4'h2, parser_done pulse at edge k.
  - Expect alu_done high only in cycle k+17.
  - Expect calc_res=32'h0002_000E and div_err=0.
- Max values: src1=16'hFFFF, src2=16'h0001 -> calc_res=32'h0000_FFFF. Then src1=16'hFFFF, src2=16'hFFFF -> calc_res=32'h0000_0001.
- Small dividend: src1=3, src2=10 -> calc_res=32'h0003_0000. Also check src1=0, src2=5 -> calc_res=32'h0000_0000.
- Divide-by-zero: src1=16'h1234, src2=0.
  - Expect alu_done in cycle k+1.
  - Expect calc_res=32'h1234_FFFF and div_err=1.
  - Then run 9/3 and expect div_err=0 and calc_res=32'h0000_0003.
- Rejected requests:
  - operator=5'h03, or dtype=4'h1, with parser_done -> no alu_done within 40 cycles; calc_res and busy unchanged.
  - parser_done pulsed during CALC -> ignored; the original result completes correctly.
- Reset mid-operation: assert n_rst low at cycle k+8 of a 100/7 divide.
  - Expect immediate IDLE, all outputs 0, and no alu_done.
  - After release, 50/6 gives calc_res=32'h0002_0008.
